// File: rtl/seg_scanner_if.sv
// Bus between the game timer and the 7-segment scanner.
//   master : game timer side, drives game_over and the four digit patterns
//   slave  : scanner side, drives the shared segment bus, dp and anodes
// All segment/anode/dp signals are active-low; segment bit6=a .. bit0=g.
interface seg_scanner_if;
  logic       game_over;
  logic [6:0] led_sec_l;
  logic [6:0] led_sec_h;
  logic [6:0] led_min_l;
  logic [6:0] led_min_h;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;

  modport master (
    output game_over, led_sec_l, led_sec_h, led_min_l, led_min_h,
    input  seg, dp, an
  );

  modport slave (
    input  game_over, led_sec_l, led_sec_h, led_min_l, led_min_h,
    output seg, dp, an
  );
endinterface

// File: rtl/seg_scanner.sv
// Time-multiplexed 4-digit common-anode 7-segment scanner.
// Ports:
//   clk  - system clock
//   rst  - synchronous reset, active-low
//   bus  - seg_scanner_if.slave: game_over + four digit patterns in,
//          seg/dp/an out (all active-low, registered)
// Digit k is lit while idx==k. Each slot starts with BLANK_CYC cycles of all
// anodes off to hide ghosting. Patterns are captured into shadow registers
// only at the frame boundary so a frame never mixes old and new digits.
// While game_over is held, the display toggles off/on every BLINK_FRAMES frames.
module seg_scanner #(
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned BLANK_CYC    = 500,
  parameter int unsigned BLINK_FRAMES = 250
) (
  input  logic          clk,
  input  logic          rst,
  seg_scanner_if.slave  bus
);

  localparam int unsigned PRE_W  = $clog2(SCAN_DIV);
  localparam int unsigned FCNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(SCAN_DIV - 1);
  localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(BLINK_FRAMES - 1);

  logic [PRE_W-1:0]  pre;
  logic [1:0]        idx;
  logic [FCNT_W-1:0] fcnt;
  logic              phase;
  logic [3:0][6:0]   shadow;

  logic [3:0] an_q;
  logic [6:0] seg_q;
  logic       dp_q;

  logic slot_end_c;
  logic frame_end_c;
  logic blank_c;
  logic off_c;

  assign slot_end_c  = (pre == PRE_LAST);
  assign frame_end_c = slot_end_c && (idx == 2'd3);

  // Ghost-suppression window at the start of every slot; absent when BLANK_CYC is 0.
  generate
    if (BLANK_CYC == 0) begin : g_no_blank
      assign blank_c = 1'b0;
    end else begin : g_blank
      assign blank_c = (pre < PRE_W'(BLANK_CYC));
    end
  endgenerate

  assign off_c = blank_c || phase;

  // Slot prescaler and digit index.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pre <= '0;
      idx <= '0;
    end else if (slot_end_c) begin
      pre <= '0;
      idx <= idx + 2'd1;
    end else begin
      pre <= pre + PRE_W'(1);
    end
  end

  // Shadow capture at the frame boundary only (tear-free frames).
  always_ff @(posedge clk) begin
    if (!rst) begin
      shadow <= {4{7'h7F}};
    end else if (frame_end_c) begin
      shadow <= {bus.led_min_h, bus.led_min_l, bus.led_sec_h, bus.led_sec_l};
    end
  end

  // Blink frame counter; dropping game_over clears it immediately.
  always_ff @(posedge clk) begin
    if (!rst) begin
      fcnt  <= '0;
      phase <= 1'b0;
    end else if (!bus.game_over) begin
      fcnt  <= '0;
      phase <= 1'b0;
    end else if (frame_end_c) begin
      if (fcnt == FCNT_LAST) begin
        fcnt  <= '0;
        phase <= ~phase;
      end else begin
        fcnt <= fcnt + FCNT_W'(1);
      end
    end
  end

  // Registered drive: one anode at most, colon dot on the min-units digit.
  always_ff @(posedge clk) begin
    if (!rst) begin
      an_q  <= 4'hF;
      seg_q <= 7'h7F;
      dp_q  <= 1'b1;
    end else begin
      an_q  <= off_c ? 4'hF : ~(4'b0001 << idx);
      seg_q <= off_c ? 7'h7F : shadow[idx];
      dp_q  <= !(!off_c && (idx == 2'd2));
    end
  end

  assign bus.an  = an_q;
  assign bus.seg = seg_q;
  assign bus.dp  = dp_q;

endmodule

// File: tb/tb_seg_scanner.sv
// Directed bench for seg_scanner with SCAN_DIV=8, BLINK_FRAMES=2.
// dut uses BLANK_CYC=2; dut0 uses BLANK_CYC=0 with game_over held low.
// Expected outputs are derived from the cycle count since reset release:
// the output seen after release edge k reflects scan position c=k-1.
module tb_seg_scanner;

  logic clk;
  logic rst;
  logic game_over;
  logic [6:0] sec_l, sec_h, min_l, min_h;

  int cyc;
  int n_checks;
  int n_fail;
  logic [3:0][6:0] exp_sh;

  seg_scanner_if bus ();
  seg_scanner_if bus0 ();

  assign bus.game_over  = game_over;
  assign bus.led_sec_l  = sec_l;
  assign bus.led_sec_h  = sec_h;
  assign bus.led_min_l  = min_l;
  assign bus.led_min_h  = min_h;
  assign bus0.game_over = 1'b0;
  assign bus0.led_sec_l = sec_l;
  assign bus0.led_sec_h = sec_h;
  assign bus0.led_min_l = min_l;
  assign bus0.led_min_h = min_h;

  seg_scanner #(.SCAN_DIV(8), .BLANK_CYC(2), .BLINK_FRAMES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  seg_scanner #(.SCAN_DIV(8), .BLANK_CYC(0), .BLINK_FRAMES(2)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scan positions (c) during which the blink phase blanks the main dut.
  function automatic bit in_blink(input int c);
    return (c >= 192 && c < 205) || (c >= 288 && c < 352);
  endfunction

  task automatic expect_out(input string tag, input int c, input bit off,
                            input logic [3:0] an, input logic [6:0] seg, input logic dp);
    int i;
    logic [3:0] ea;
    logic [6:0] es;
    logic       ed;
    i  = (c / 8) % 4;
    ea = 4'hF;
    es = 7'h7F;
    ed = 1'b1;
    if (!off) begin
      ea[i] = 1'b0;
      es    = exp_sh[i];
      ed    = (i == 2) ? 1'b0 : 1'b1;
    end
    check($sformatf("%s an c=%0d", tag, c), 32'(an), 32'(ea));
    check($sformatf("%s seg c=%0d", tag, c), 32'(seg), 32'(es));
    check($sformatf("%s dp c=%0d", tag, c), 32'(dp), 32'(ed));
  endtask

  task automatic step();
    int c;
    int p;
    @(posedge clk);
    #1;
    cyc++;
    c = cyc - 1;
    p = c % 8;
    expect_out("main", c, (p < 2) || in_blink(c), bus.an, bus.seg, bus.dp);
    expect_out("nob", c, 1'b0, bus0.an, bus0.seg, bus0.dp);
    if (c % 32 == 31) exp_sh = {min_h, min_l, sec_h, sec_l};
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " an"}, 32'(bus.an), 32'hF);
    check({tag, " seg"}, 32'(bus.seg), 32'h7F);
    check({tag, " dp"}, 32'(bus.dp), 32'h1);
    check({tag, " an0"}, 32'(bus0.an), 32'hF);
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    cyc       = 0;
    rst       = 1'b0;
    game_over = 1'b1;
    sec_l     = 7'b0000000;
    sec_h     = 7'b0101010;
    min_l     = 7'b0000000;
    min_h     = 7'b1010101;
    exp_sh    = {4{7'h7F}};

    // Reset held for three edges with game_over high.
    repeat (3) begin
      @(posedge clk);
      #1;
      check_reset_outputs("reset");
    end

    rst       = 1'b1;
    game_over = 1'b0;
    sec_l     = 7'b0000001;
    sec_h     = 7'b1001111;
    min_l     = 7'b0010010;
    min_h     = 7'b0000110;

    // Frame 1 blank shadows, frame 2 onward shows the patterns.
    while (cyc < 75) step();
    // Tear-free: idx=1, pre=3 in frame 3.
    sec_l = 7'b1001100;
    while (cyc < 128) step();
    // Blink from a frame start.
    game_over = 1'b1;
    while (cyc < 204) step();
    // Deassert mid-blink-blank at pre=4 of digit 1.
    game_over = 1'b0;
    while (cyc < 224) step();
    game_over = 1'b1;
    while (cyc < 360) step();
    game_over = 1'b0;
    while (cyc < 373) step();

    // Mid-operation reset at idx=2, pre=5.
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_reset_outputs("midreset");
    rst    = 1'b1;
    cyc    = 0;
    exp_sh = {4{7'h7F}};
    repeat (40) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
